// File: rtl/mvb_deserializer_param.sv
// MVB receive-path deserializer: one bit per clk_3M edge into a WIDTH-bit word,
// handed to the frame layer through a valid/ready holding register.
module mvb_deserializer_param #(
  parameter int WIDTH         = 16,
  parameter bit MSB_FIRST     = 1'b1,
  parameter bit FLUSH_PARTIAL = 1'b0,
  parameter int LEN_W         = $clog2(WIDTH + 1)
) (
  input  logic             clk_3M,
  input  logic             rst,
  input  logic             deserializer_wait,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [LEN_W-1:0] data_len,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic [15:0]      word_cnt
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d, pos;
  logic [WIDTH-1:0]   shreg_q, shreg_d, shreg_upd, offer_data;
  logic [LEN_W-1:0]   offer_len;
  logic               offer, accept, load;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    offer      = 1'b0;
    offer_data = shreg_q;
    offer_len  = LEN_W'(bit_cnt_q);
    pos        = MSB_FIRST ? (CNT_W'(WIDTH - 1) - bit_cnt_q) : bit_cnt_q;
    shreg_upd  = shreg_q;
    shreg_upd[pos] = data_in;

    if (!deserializer_wait) begin
      state_d = SHIFT;
      if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
        // Final bit: offer the word including this bit and restart with no gap.
        offer      = 1'b1;
        offer_data = shreg_upd;
        offer_len  = LEN_W'(WIDTH);
        bit_cnt_d  = '0;
        shreg_d    = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        shreg_d   = shreg_upd;
      end
    end else begin
      // Shift register is cleared at every word start, so a partial word is
      // already aligned (left for MSB-first, right for LSB-first).
      state_d   = IDLE;
      bit_cnt_d = '0;
      shreg_d   = '0;
      if (FLUSH_PARTIAL && state_q == SHIFT && bit_cnt_q != '0) offer = 1'b1;
    end
  end

  assign accept = data_valid & data_ready;
  assign load   = offer & (~data_valid | data_ready);

  always_ff @(posedge clk_3M) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      data_out   <= '0;
      data_len   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      word_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      if (accept) word_cnt <= word_cnt + 16'd1;
      if (load) begin
        data_out   <= offer_data;
        data_len   <= offer_len;
        data_valid <= 1'b1;
      end else if (accept) begin
        data_valid <= 1'b0;
      end
      if (offer && !load) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mvb_deserializer_param.sv
// Bench for mvb_deserializer_param: two configurations driven by a shared
// stream, checked every cycle against a bit-queue reference model.
module tb_mvb_deserializer_param;

  logic clk_3M = 1'b0;
  logic rst, deserializer_wait, data_in, data_ready;

  logic [15:0] d16;  logic [4:0] l16;  logic v16, ov16;  logic [15:0] c16;
  logic [7:0]  d8;   logic [3:0] l8;   logic v8, ov8;    logic [15:0] c8;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state per instance (0: 16-bit MSB-first flush, 1: 8-bit LSB-first no flush)
  bit          rxq [2][$];
  logic        ev  [2];
  logic [31:0] ed  [2];
  int          el  [2];
  logic        eov [2];
  logic [15:0] ecnt[2];

  mvb_deserializer_param #(.WIDTH(16), .MSB_FIRST(1'b1), .FLUSH_PARTIAL(1'b1)) u16 (
    .clk_3M(clk_3M), .rst(rst), .deserializer_wait(deserializer_wait), .data_in(data_in),
    .data_out(d16), .data_len(l16), .data_valid(v16), .data_ready(data_ready),
    .overrun(ov16), .word_cnt(c16));

  mvb_deserializer_param #(.WIDTH(8), .MSB_FIRST(1'b0), .FLUSH_PARTIAL(1'b0)) u8 (
    .clk_3M(clk_3M), .rst(rst), .deserializer_wait(deserializer_wait), .data_in(data_in),
    .data_out(d8), .data_len(l8), .data_valid(v8), .data_ready(data_ready),
    .overrun(ov8), .word_cnt(c8));

  always #5 clk_3M = ~clk_3M;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int   w   = (k == 0) ? 16 : 8;
    bit   msb = (k == 0);
    bit   fl  = (k == 0);
    bit   offer, acc, ld;
    logic [31:0] word;
    int   len;
    if (rst) begin
      rxq[k].delete();
      ev[k] = 1'b0; ed[k] = '0; el[k] = 0; eov[k] = 1'b0; ecnt[k] = '0;
      return;
    end
    acc   = ev[k] && data_ready;
    offer = 1'b0;
    if (!deserializer_wait) begin
      rxq[k].push_back(data_in);
      offer = (rxq[k].size() == w);
    end else begin
      offer = fl && (rxq[k].size() > 0);
    end
    word = '0;
    len  = rxq[k].size();
    for (int i = 0; i < len; i++)
      if (rxq[k][i]) word = word + (32'd1 << (msb ? (w - 1 - i) : i));
    if (offer || deserializer_wait) rxq[k].delete();
    ld = offer && (!ev[k] || data_ready);
    if (acc) ecnt[k] = ecnt[k] + 16'd1;
    if (ld) begin
      ev[k] = 1'b1; ed[k] = word; el[k] = len;
    end else if (acc) begin
      ev[k] = 1'b0;
    end
    if (offer && !ld) eov[k] = 1'b1;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      string p = (k == 0) ? "u16" : "u8";
      check({p, ".valid"},    32'(k == 0 ? v16 : v8),   32'(ev[k]));
      if (ev[k]) begin
        check({p, ".data"},   (k == 0) ? 32'(d16) : 32'(d8), ed[k]);
        check({p, ".len"},    (k == 0) ? 32'(l16) : 32'(l8), el[k]);
      end
      check({p, ".overrun"},  32'(k == 0 ? ov16 : ov8), 32'(eov[k]));
      check({p, ".word_cnt"}, 32'(k == 0 ? c16 : c8),   32'(ecnt[k]));
    end
  endtask

  // Called at a falling edge: drive, let the rising edge happen, check at the next falling edge.
  task automatic step(input logic w, input logic d, input logic r);
    deserializer_wait = w;
    data_in           = d;
    data_ready        = r;
    @(posedge clk_3M);
    model_step(0);
    model_step(1);
    @(negedge clk_3M);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] val, input int nbits, input bit msb, input logic r);
    for (int i = 0; i < nbits; i++)
      step(1'b0, msb ? val[nbits - 1 - i] : val[i], r);
  endtask

  initial begin
    rst = 1'b1; deserializer_wait = 1'b1; data_in = 1'b0; data_ready = 1'b0;
    @(negedge clk_3M);

    // Reset state
    do_reset();
    check("rst.data_out", 32'(d16), 32'h0);
    check("rst.data_len", 32'(l16), 32'h0);
    check("rst.valid",    32'(v16), 32'h0);

    // Full 16-bit word, MSB first, latency 1
    send_word(16'hA5C3, 16, 1'b1, 1'b1);
    check("a5c3.valid", 32'(v16), 32'h1);
    check("a5c3.data",  32'(d16), 32'hA5C3);
    check("a5c3.len",   32'(l16), 32'd16);
    step(1'b1, 1'b0, 1'b1);
    check("a5c3.cnt",   32'(c16), 32'd1);

    // Back-to-back 8-bit LSB-first words
    do_reset();
    send_word(16'h003C, 8, 1'b0, 1'b1);
    check("w8a.data", 32'(d8), 32'h3C);
    send_word(16'h0081, 8, 1'b0, 1'b1);
    check("w8b.valid", 32'(v8),  32'h1);
    check("w8b.data",  32'(d8),  32'h81);
    check("w8b.ovr",   32'(ov8), 32'h0);
    step(1'b1, 1'b0, 1'b1);

    // Overrun with consumer stalled
    do_reset();
    send_word(16'h1111, 16, 1'b1, 1'b0);
    send_word(16'h2222, 16, 1'b1, 1'b0);
    check("ovr.set",  32'(ov16), 32'h1);
    send_word(16'h3333, 16, 1'b1, 1'b0);
    check("ovr.hold", 32'(d16),  32'h1111);
    step(1'b1, 1'b0, 1'b1);
    check("ovr.cnt",   32'(c16), 32'd1);
    check("ovr.valid", 32'(v16), 32'h0);

    // Partial-word flush (u16 flushes, u8 discards)
    do_reset();
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("flush.valid", 32'(v16), 32'h1);
    check("flush.data",  32'(d16), 32'hB000);
    check("flush.len",   32'(l16), 32'd5);
    check("noflush.valid", 32'(v8), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check("flush.once", 32'(c16), 32'd1);

    // Reset mid-word while a word is pending
    do_reset();
    send_word(16'h1234, 16, 1'b1, 1'b0);
    send_word(16'h01FF, 9, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    check("mrst.valid", 32'(v16),  32'h0);
    check("mrst.data",  32'(d16),  32'h0);
    check("mrst.ovr",   32'(ov16), 32'h0);
    send_word(16'h5A5A, 16, 1'b1, 1'b1);
    check("mrst.restart", 32'(d16), 32'h5A5A);

    // word_cnt wrap
    do_reset();
    force u16.word_cnt = 16'hFFFE;
    #1;
    release u16.word_cnt;
    ecnt[0] = 16'hFFFE;
    send_word(16'hC001, 16, 1'b1, 1'b1);
    send_word(16'hC002, 16, 1'b1, 1'b1);
    send_word(16'hC003, 16, 1'b1, 1'b1);
    check("wrap.cnt",   32'(c16), 32'h0);
    check("wrap.valid", 32'(v16), 32'h1);
    step(1'b1, 1'b0, 1'b1);
    check("wrap.cnt1",  32'(c16), 32'h1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      step($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
